// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB and the MCU result path,
// with a bounded-starvation stall and a busy scoreboard for in-flight MCU destinations.
module rf_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  async_rst_n,

    input  logic                  i_wb_valid,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_wb_stall,

    input  logic                  i_mcu_issue_valid,
    input  logic [ADDR_WIDTH-1:0] i_mcu_issue_rd,
    output logic                  o_mcu_issue_ready,

    input  logic                  i_mcu_res_valid,
    input  logic [ADDR_WIDTH-1:0] i_mcu_res_addr,
    input  logic [DATA_WIDTH-1:0] i_mcu_res_data,
    output logic                  o_mcu_res_ready,

    input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_rd_busy,

    output logic                  o_rf_write_enable,
    output logic [ADDR_WIDTH-1:0] o_rf_write_addr,
    output logic [DATA_WIDTH-1:0] o_rf_write_data
);

    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

    logic                  r_wb_stall;
    logic [CNT_W-1:0]      r_cnt;
    logic [NREG-1:0]       r_busy;
    logic [NREG-1:0]       w_busy_nxt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_wb_grant;
    logic                  w_mcu_grant;
    logic                  w_any_grant;
    logic                  w_mcu_lost;
    logic                  w_issue_acc;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // WB wins whenever it is not being held off by the anti-starvation stall.
    assign w_wb_grant  = i_wb_valid & ~r_wb_stall;
    assign w_mcu_grant = i_mcu_res_valid & ~w_wb_grant;
    assign w_any_grant = w_wb_grant | w_mcu_grant;
    assign w_mcu_lost  = i_mcu_res_valid & w_wb_grant;
    assign w_sel_addr  = w_wb_grant ? i_wb_addr : i_mcu_res_addr;
    assign w_sel_data  = w_wb_grant ? i_wb_data : i_mcu_res_data;

    assign o_mcu_res_ready   = ~w_wb_grant;
    assign o_mcu_issue_ready = ~r_busy[i_mcu_issue_rd];
    assign w_issue_acc       = i_mcu_issue_valid & o_mcu_issue_ready;

    assign o_rs1_busy = r_busy[i_rs1_addr];
    assign o_rs2_busy = r_busy[i_rs2_addr];
    assign o_rd_busy  = r_busy[i_rd_addr];

    assign o_wb_stall        = r_wb_stall;
    assign o_rf_write_enable = r_we;
    assign o_rf_write_addr   = r_waddr;
    assign o_rf_write_data   = r_wdata;

    // Registered write port; addr/data hold between grants.
    always_ff @(posedge i_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_any_grant && (w_sel_addr != '0);
            if (w_any_grant) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    // The stall always lasts one cycle; during it WB cannot be granted, so the
    // MCU takes the port and the lost streak restarts from zero.
    always_ff @(posedge i_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_wb_stall <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_wb_stall <= 1'b0;
            if (w_mcu_lost) begin
                if (r_cnt == CNT_MAX) begin
                    r_wb_stall <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Set and clear never target the same index: issue is refused while busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_mcu_grant)
            w_busy_nxt[i_mcu_res_addr] = 1'b0;
        if (w_issue_acc)
            w_busy_nxt[i_mcu_issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge async_rst_n) begin
        if (!async_rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;

    logic          clk;
    logic          async_rst_n;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_stall;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;
    logic          res_valid;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic          rs1_busy, rs2_busy, rd_busy;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;

    int checks = 0;
    int failures = 0;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .i_clk(clk), .async_rst_n(async_rst_n),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_stall(wb_stall),
        .i_mcu_issue_valid(issue_valid), .i_mcu_issue_rd(issue_rd), .o_mcu_issue_ready(issue_ready),
        .i_mcu_res_valid(res_valid), .i_mcu_res_addr(res_addr), .i_mcu_res_data(res_data),
        .o_mcu_res_ready(res_ready),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr),
        .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_rd_busy(rd_busy),
        .o_rf_write_enable(rf_we), .o_rf_write_addr(rf_addr), .o_rf_write_data(rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic set_idle();
        wb_valid = 0; wb_addr = '0; wb_data = '0;
        issue_valid = 0; issue_rd = '0;
        res_valid = 0; res_addr = '0; res_data = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        set_idle();
        async_rst_n = 0; #1; async_rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        issue_valid = 1; issue_rd = 5'd3; step();
        issue_rd = 5'd9; step();
        issue_valid = 0;
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hA5A5A5A5;
        res_valid = 1; res_addr = 5'd0; res_data = 32'h1;
        repeat (SL) step();
        rs1_addr = 5'd3; rs2_addr = 5'd9; rd_addr = 5'd9; issue_rd = 5'd9; #1;
        checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL pre_reset_stall got=%0h exp=1", wb_stall); end
        checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%0h%0h exp=11", rs1_busy, rs2_busy); end
        async_rst_n = 0; #1;
        checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", wb_stall); end
        checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin failures++; $display("FAIL reset_rf got=%0h/%0h/%0h exp=0/0/0", rf_we, rf_addr, rf_data); end
        checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || rd_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h%0h%0h exp=000", rs1_busy, rs2_busy, rd_busy); end
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%0h exp=1", issue_ready); end
        checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL reset_res_ready_wb got=%0h exp=0", res_ready); end
        wb_valid = 0; #1;
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL reset_res_ready_idle got=%0h exp=1", res_ready); end
        async_rst_n = 1;
        set_idle();
        step();
    endtask

    task automatic test_wb_write();
        do_reset();
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        wb_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wb_write got=%0h/%0h/%0h exp=1/5/deadbeef", rf_we, rf_addr, rf_data); end
        step();
        checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd5) begin failures++; $display("FAIL wb_write_off got=%0h/%0h exp=0/5", rf_we, rf_addr); end
    endtask

    task automatic test_x0();
        do_reset();
        wb_valid = 1; wb_addr = 5'd6; wb_data = 32'h66;
        step();
        wb_addr = 5'd0; wb_data = 32'h1234;
        step();
        wb_valid = 0;
        checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'h1234) begin failures++; $display("FAIL wb_x0 got=%0h/%0h/%0h exp=0/0/1234", rf_we, rf_addr, rf_data); end
        res_valid = 1; res_addr = 5'd0; res_data = 32'h77; #1;
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL mcu_x0_ready got=%0h exp=1", res_ready); end
        step();
        res_valid = 0;
        checks++; if (rf_we !== 1'b0 || rf_data !== 32'h77) begin failures++; $display("FAIL mcu_x0 got=%0h/%0h exp=0/77", rf_we, rf_data); end
    endtask

    task automatic test_starve();
        do_reset();
        wb_valid = 1; wb_addr = 5'd1; wb_data = 32'h100;
        res_valid = 1; res_addr = 5'd7; res_data = 32'h1234;
        for (int c = 0; c <= SL + 1; c++) begin
            #1;
            if (c < SL) begin
                checks++; if (res_ready !== 1'b0 || wb_stall !== 1'b0) begin failures++; $display("FAIL starve_wait c=%0d got=%0h/%0h exp=0/0", c, res_ready, wb_stall); end
            end else if (c == SL) begin
                checks++; if (res_ready !== 1'b1 || wb_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%0h/%0h exp=1/1", res_ready, wb_stall); end
            end else begin
                checks++; if (res_ready !== 1'b0 || wb_stall !== 1'b0) begin failures++; $display("FAIL starve_after got=%0h/%0h exp=0/0", res_ready, wb_stall); end
            end
            step();
            if (c == SL) begin
                res_valid = 0;
                checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'h1234) begin failures++; $display("FAIL starve_mcu_write got=%0h/%0h/%0h exp=1/7/1234", rf_we, rf_addr, rf_data); end
            end else begin
                checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd1 || rf_data !== 32'h100) begin failures++; $display("FAIL starve_wb_write c=%0d got=%0h/%0h/%0h exp=1/1/100", c, rf_we, rf_addr, rf_data); end
            end
        end
        set_idle();
    endtask

    task automatic test_cnt_clear();
        do_reset();
        wb_valid = 1; wb_addr = 5'd2; wb_data = 32'h2;
        res_valid = 1; res_addr = 5'd8; res_data = 32'h88;
        step(); step();
        wb_valid = 0; #1;
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL idle_grant_ready got=%0h exp=1", res_ready); end
        step();
        res_data = 32'h99; wb_valid = 1;
        for (int c = 0; c < SL; c++) begin
            #1;
            checks++; if (wb_stall !== 1'b0 || res_ready !== 1'b0) begin failures++; $display("FAIL cnt_clear c=%0d got=%0h/%0h exp=0/0", c, wb_stall, res_ready); end
            step();
        end
        checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL cnt_clear_stall got=%0h exp=1", wb_stall); end
        step();
        set_idle();
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1; issue_rd = 5'd9; #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_issue_ready got=%0h exp=1", issue_ready); end
        step();
        rs1_addr = 5'd9; #1;
        checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL sb_rs1_busy got=%0h exp=1", rs1_busy); end
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sb_reissue got=%0h exp=0", issue_ready); end
        step();
        issue_rd = 5'd10;
        res_valid = 1; res_addr = 5'd9; res_data = 32'hCAFE; #1;
        checks++; if (issue_ready !== 1'b1 || res_ready !== 1'b1) begin failures++; $display("FAIL sb_simul_ready got=%0h/%0h exp=1/1", issue_ready, res_ready); end
        step();
        set_idle();
        rs1_addr = 5'd9; rs2_addr = 5'd10; rd_addr = 5'd10; #1;
        checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1 || rd_busy !== 1'b1) begin failures++; $display("FAIL sb_set_clear got=%0h%0h%0h exp=011", rs1_busy, rs2_busy, rd_busy); end
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'hCAFE) begin failures++; $display("FAIL sb_write got=%0h/%0h/%0h exp=1/9/cafe", rf_we, rf_addr, rf_data); end
        step();
    endtask

    task automatic test_idle_mcu();
        do_reset();
        res_valid = 1; res_addr = 5'd12; res_data = 32'h55; #1;
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL idle_mcu_ready got=%0h exp=1", res_ready); end
        step();
        res_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd12 || rf_data !== 32'h55) begin failures++; $display("FAIL idle_mcu_write got=%0h/%0h/%0h exp=1/c/55", rf_we, rf_addr, rf_data); end
    endtask

    task automatic test_random();
        logic          m_stall, m_we, e_wbg, e_mg, e_ir;
        int            m_lost;
        logic [31:0]   m_busy;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data;
        logic [AW-1:0] q[$];
        do_reset();
        m_stall = 0; m_lost = 0; m_busy = '0; m_we = 0; m_addr = '0; m_data = '0;
        for (int c = 0; c < 600; c++) begin
            // WB stays put while stalled; MCU result stays put until accepted.
            if (!m_stall) begin
                wb_valid = ($urandom % 10) < 7;
                wb_addr  = AW'($urandom);
                wb_data  = $urandom;
            end
            if (!res_valid && q.size() != 0 && ($urandom % 2) == 1) begin
                res_addr = q.pop_front(); res_data = $urandom; res_valid = 1;
            end
            issue_valid = (q.size() < 8) && (($urandom % 10) < 4);
            issue_rd = AW'($urandom);
            rs1_addr = AW'($urandom); rs2_addr = AW'($urandom); rd_addr = AW'($urandom);
            #1;
            e_wbg = wb_valid && !m_stall;
            e_mg  = res_valid && !e_wbg;
            e_ir  = !m_busy[issue_rd];
            checks++; if (wb_stall !== m_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0h exp=%0h", c, wb_stall, m_stall); end
            checks++; if (res_ready !== !e_wbg) begin failures++; $display("FAIL rnd_res_ready c=%0d got=%0h exp=%0h", c, res_ready, !e_wbg); end
            checks++; if (issue_ready !== e_ir) begin failures++; $display("FAIL rnd_issue_ready c=%0d got=%0h exp=%0h", c, issue_ready, e_ir); end
            checks++; if ({rs1_busy, rs2_busy, rd_busy} !== {m_busy[rs1_addr], m_busy[rs2_addr], m_busy[rd_addr]}) begin
                failures++; $display("FAIL rnd_lookup c=%0d got=%0h%0h%0h exp=%0h%0h%0h", c, rs1_busy, rs2_busy, rd_busy, m_busy[rs1_addr], m_busy[rs2_addr], m_busy[rd_addr]);
            end
            step();
            if (e_wbg) begin
                m_we = (wb_addr != 0); m_addr = wb_addr; m_data = wb_data;
            end else if (e_mg) begin
                m_we = (res_addr != 0); m_addr = res_addr; m_data = res_data;
            end else begin
                m_we = 0;
            end
            if (m_stall) begin
                m_stall = 0; m_lost = 0;
            end else if (res_valid && e_wbg) begin
                m_lost++;
                if (m_lost == SL) begin m_stall = 1; m_lost = 0; end
            end else begin
                m_lost = 0;
            end
            if (e_mg && res_addr != 0) m_busy[res_addr] = 1'b0;
            if (issue_valid && e_ir) begin
                if (issue_rd != 0) m_busy[issue_rd] = 1'b1;
                q.push_back(issue_rd);
            end
            if (e_mg) res_valid = 0;
            checks++; if (rf_we !== m_we) begin failures++; $display("FAIL rnd_we c=%0d got=%0h exp=%0h", c, rf_we, m_we); end
            checks++; if (rf_addr !== m_addr || rf_data !== m_data) begin failures++; $display("FAIL rnd_wdata c=%0d got=%0h/%0h exp=%0h/%0h", c, rf_addr, rf_data, m_addr, m_data); end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        async_rst_n = 0;
        step();
        async_rst_n = 1;
        test_reset();
        test_wb_write();
        test_x0();
        test_starve();
        test_cnt_clear();
        test_scoreboard();
        test_idle_mcu();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
